// File: rtl/exp5_mostra_sequencia_if.sv
// Control/memory bus of the sequence presenter: iniciar/pronto handshake plus memory address/data.
// The slave modport is the presenter; the master modport is the control unit and memory side.
interface exp5_mostra_sequencia_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              iniciar;
  logic [ADDR_W-1:0] limite;
  logic              pronto;
  logic              mostrando;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] dado_mem;

  modport master (
    output iniciar, limite, dado_mem,
    input  pronto, mostrando, endereco
  );

  modport slave (
    input  iniciar, limite, dado_mem,
    output pronto, mostrando, endereco
  );
endinterface

// File: rtl/exp5_mostra_sequencia.sv
// Memory-game presenter: lights stored positions 0..limite on the LEDs, then pulses pronto.
// Optional macro MOSTRA_PULAR_EN adds input pular, which skips straight to the end of the show.
module exp5_mostra_sequencia #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 4,
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 250
) (
  input  logic                    clock,
  input  logic                    reset,
`ifdef MOSTRA_PULAR_EN
  input  logic                    pular,
`endif
  exp5_mostra_sequencia_if.slave  bus,
  output logic [DATA_W-1:0]       leds,
  output logic [3:0]              db_estado
);

  localparam int T_MAX   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX + 1);
  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    ACENDE  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } state_t;

  state_t              state;
  logic [TIMER_W-1:0]  timer;
  logic [ADDR_W-1:0]   endereco;
  logic [ADDR_W-1:0]   limite_reg;
  logic                skip;

`ifdef MOSTRA_PULAR_EN
  assign skip = pular;
`else
  assign skip = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= INICIAL;
      endereco   <= '0;
      timer      <= '0;
      limite_reg <= '0;
    end else if (skip && (state inside {ACENDE, APAGA, PROXIMO})) begin
      // Abort keeps endereco on the position being shown when the skip arrived.
      state <= FIM;
      timer <= '0;
    end else begin
      case (state)
        INICIAL: if (bus.iniciar) state <= PREPARA;
        PREPARA: begin
          endereco   <= '0;
          timer      <= '0;
          limite_reg <= bus.limite;
          state      <= ACENDE;
        end
        ACENDE: begin
          if (timer == ON_LAST) begin
            timer <= '0;
            state <= APAGA;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        APAGA: begin
          if (timer == OFF_LAST) begin
            timer <= '0;
            state <= (endereco == limite_reg) ? FIM : PROXIMO;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        PROXIMO: begin
          endereco <= endereco + ADDR_W'(1);
          state    <= ACENDE;
        end
        FIM:     state <= INICIAL;
        default: state <= INICIAL;
      endcase
    end
  end

  assign bus.endereco  = endereco;
  assign bus.pronto    = (state == FIM);
  assign bus.mostrando = (state inside {PREPARA, ACENDE, APAGA, PROXIMO});
  assign leds          = (state == ACENDE) ? bus.dado_mem : '0;
  assign db_estado     = state;

endmodule

// File: tb/tb_exp5_mostra_sequencia.sv
// Directed bench for exp5_mostra_sequencia with ON_CYCLES=3, OFF_CYCLES=2 and memory {1,2,4,8,...}.
// Expected per-cycle traces are built from the show schedule and compared at the falling edge.
module tb_exp5_mostra_sequencia;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int ON     = 3;
  localparam int OFF    = 2;

  // {db_estado, leds, endereco, pronto, mostrando}
  typedef logic [13:0] obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef MOSTRA_PULAR_EN
  logic pular = 1'b0;
`endif
  logic [DATA_W-1:0] leds;
  logic [3:0]        db_estado;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  logic [3:0] last_addr = 4'd0;

  exp5_mostra_sequencia_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  always #5 clock = ~clock;

  function automatic logic [3:0] mem_word(input logic [3:0] a);
    return 4'b0001 << a[1:0];
  endfunction

  assign bus.dado_mem = mem_word(bus.endereco);

  exp5_mostra_sequencia #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef MOSTRA_PULAR_EN
    .pular     (pular),
`endif
    .bus       (bus.slave),
    .leds      (leds),
    .db_estado (db_estado)
  );

  function automatic obs_t pack(input logic [3:0] st, input logic [3:0] lv, input logic [3:0] ad,
                                input logic pr, input logic mo);
    return {st, lv, ad, pr, mo};
  endfunction

  function automatic obs_t observe();
    return {db_estado, leds, bus.endereco, bus.pronto, bus.mostrando};
  endfunction

  // Schedule: PREPARA, then per address ON lit + OFF blank + PROXIMO/FIM, then INICIAL.
  function automatic void build_trace(input int lim);
    exp_q.delete();
    exp_q.push_back(pack(4'd1, 4'd0, last_addr, 1'b0, 1'b1));
    for (int a = 0; a <= lim; a++) begin
      for (int c = 0; c < ON; c++)  exp_q.push_back(pack(4'd2, mem_word(4'(a)), 4'(a), 1'b0, 1'b1));
      for (int c = 0; c < OFF; c++) exp_q.push_back(pack(4'd3, 4'd0, 4'(a), 1'b0, 1'b1));
      if (a < lim) exp_q.push_back(pack(4'd4, 4'd0, 4'(a), 1'b0, 1'b1));
      else         exp_q.push_back(pack(4'd5, 4'd0, 4'(a), 1'b1, 1'b0));
    end
    exp_q.push_back(pack(4'd0, 4'd0, 4'(lim), 1'b0, 1'b0));
    last_addr = 4'(lim);
  endfunction

  task automatic test_reset();
    bus.iniciar = 1'b0;
    bus.limite  = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (observe() !== pack(4'd0, 4'd0, 4'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_state got %h expected %h", observe(), pack(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (observe() !== pack(4'd0, 4'd0, 4'd0, 1'b0, 1'b0)) begin
        errors++;
        $display("FAIL idle_hold cycle %0d got %h expected %h", k, observe(), pack(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_single();
    bus.limite  = 4'd0;
    bus.iniciar = 1'b1;
    build_trace(0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      if (k == 0) bus.iniciar = 1'b0;
      checks++;
      if (observe() !== exp_q[k]) begin
        errors++;
        $display("FAIL single cycle %0d got %h expected %h", k + 1, observe(), exp_q[k]);
      end
    end
  endtask

  task automatic test_full();
    int pronto_at;
    pronto_at   = -1;
    bus.limite  = 4'd3;
    bus.iniciar = 1'b1;
    build_trace(3);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      if (k == 0) bus.iniciar = 1'b0;
      if (bus.pronto === 1'b1 && pronto_at < 0) pronto_at = k + 1;
      checks++;
      if (observe() !== exp_q[k]) begin
        errors++;
        $display("FAIL full cycle %0d got %h expected %h", k + 1, observe(), exp_q[k]);
      end
    end
    checks++;
    if (pronto_at !== 25) begin
      errors++;
      $display("FAIL full_latency got %0d expected 25", pronto_at);
    end
  endtask

  task automatic test_limite_change();
    bus.limite  = 4'd3;
    bus.iniciar = 1'b1;
    build_trace(3);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      if (k == 0) bus.iniciar = 1'b0;
      if (k == 1) bus.limite  = 4'd0;
      checks++;
      if (observe() !== exp_q[k]) begin
        errors++;
        $display("FAIL limite_change cycle %0d got %h expected %h", k + 1, observe(), exp_q[k]);
      end
    end
  endtask

  task automatic test_retrigger();
    bus.limite  = 4'd0;
    bus.iniciar = 1'b1;
    build_trace(0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      checks++;
      if (observe() !== exp_q[k]) begin
        errors++;
        $display("FAIL retrigger cycle %0d got %h expected %h", k + 1, observe(), exp_q[k]);
      end
    end
    @(negedge clock);
    bus.iniciar = 1'b0;
    checks++;
    if (observe() !== pack(4'd1, 4'd0, 4'd0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL retrigger_restart got %h expected %h", observe(), pack(4'd1, 4'd0, 4'd0, 1'b0, 1'b1));
    end
    build_trace(0);
    for (int k = 1; k < exp_q.size(); k++) begin
      @(negedge clock);
      checks++;
      if (observe() !== exp_q[k]) begin
        errors++;
        $display("FAIL retrigger_second cycle %0d got %h expected %h", k + 1, observe(), exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic saw;
    saw         = 1'b0;
    bus.limite  = 4'd3;
    bus.iniciar = 1'b1;
    build_trace(3);
    // Trace index 13 is cycle 14: first ACENDE cycle of address 2.
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      if (k == 0) bus.iniciar = 1'b0;
      checks++;
      if (observe() !== exp_q[k]) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d got %h expected %h", k + 1, observe(), exp_q[k]);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_addr = 4'd0;
    checks++;
    if (observe() !== pack(4'd0, 4'd0, 4'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid got %h expected %h", observe(), pack(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.pronto !== 1'b0 || db_estado !== 4'd0) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %b expected 0", saw);
    end
  endtask

`ifdef MOSTRA_PULAR_EN
  task automatic test_pular();
    bus.limite  = 4'd3;
    bus.iniciar = 1'b1;
    build_trace(3);
    // Trace index 7 is cycle 8: first ACENDE cycle of address 1.
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 0) bus.iniciar = 1'b0;
      checks++;
      if (observe() !== exp_q[k]) begin
        errors++;
        $display("FAIL pular_pre cycle %0d got %h expected %h", k + 1, observe(), exp_q[k]);
      end
    end
    pular = 1'b1;
    @(negedge clock);
    pular = 1'b0;
    checks++;
    if (observe() !== pack(4'd5, 4'd0, 4'd1, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL pular_fim got %h expected %h", observe(), pack(4'd5, 4'd0, 4'd1, 1'b1, 1'b0));
    end
    @(negedge clock);
    checks++;
    if (observe() !== pack(4'd0, 4'd0, 4'd1, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL pular_idle got %h expected %h", observe(), pack(4'd0, 4'd0, 4'd1, 1'b0, 1'b0));
    end
    last_addr = 4'd1;
  endtask
`endif

  task automatic test_wrap();
    bus.limite  = 4'd15;
    bus.iniciar = 1'b1;
    build_trace(15);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clock);
      if (k == 0) bus.iniciar = 1'b0;
      checks++;
      if (observe() !== exp_q[k]) begin
        errors++;
        $display("FAIL wrap cycle %0d got %h expected %h", k + 1, observe(), exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_limite_change();
    test_retrigger();
    test_reset_mid();
`ifdef MOSTRA_PULAR_EN
    test_pular();
`endif
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
